// File: rtl/input_debounce.sv
// ---------------------------------------------------------------------------
// input_debounce
//
// Two-channel switch/contact debouncer. Each raw input is brought into the
// clk domain through a two-flop synchronizer and then filtered by a small
// FSM. The FSM only accepts a new level after DEBOUNCE_CYCLES consecutive
// synchronized samples agree. Shorter pulses are discarded without touching
// the output. The two channels are fully independent.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable samples needed to accept a change
//                     (1..255, at most 2^CNT_W - 1)
//   CNT_W           : stability counter width
//
// Ports
//   clk     in   clock, all state changes on the rising edge
//   reset   in   synchronous, active-high reset
//   a_raw   in   asynchronous, possibly bouncing channel A
//   b_raw   in   asynchronous, possibly bouncing channel B
//   a       out  registered debounced level of channel A
//   b       out  registered debounced level of channel B
//   a_edge  out  one-cycle pulse on every accepted change of a
//   b_edge  out  one-cycle pulse on every accepted change of b
// ---------------------------------------------------------------------------

module InputDebounceChannel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_edge
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } state_t;

  // The edge on which the FSM first notices a new level in a STABLE state
  // already counts as the first agreeing sample. Inside a CHK state cnt
  // therefore holds the number of further agreeing samples seen so far.
  // The change is accepted once cnt reaches DEBOUNCE_CYCLES-2, which
  // makes DEBOUNCE_CYCLES agreeing samples in total. With a single
  // required sample the STABLE state accepts the change directly.
  localparam logic [CNT_W-1:0] LAST_CNT =
    (DEBOUNCE_CYCLES >= 2) ? CNT_W'(DEBOUNCE_CYCLES - 2) : '0;
  localparam bit IMMEDIATE = (DEBOUNCE_CYCLES == 1);

  logic             r_s1;
  logic             r_s2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_edge;

  state_t           w_nextState;
  logic [CNT_W-1:0] w_nextCnt;
  logic             w_nextLevel;
  logic             w_nextEdge;

  // Plain two-flop synchronizer. No logic sits between r_s1 and r_s2, so
  // r_s1 has a full cycle to resolve metastability.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  // State register. The level and the edge pulse are registered alongside
  // the state so that both outputs change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_level <= w_nextLevel;
      r_edge  <= w_nextEdge;
    end
  end

  // Next-state logic. The counter is cleared on every exit from a CHK
  // state and never goes past LAST_CNT, so it cannot wrap.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextLevel = r_level;
    w_nextEdge  = 1'b0;

    case (r_state)
      STABLE_LO: begin
        if (r_s2) begin
          w_nextCnt = '0;
          if (IMMEDIATE) begin
            w_nextState = STABLE_HI;
            w_nextLevel = 1'b1;
            w_nextEdge  = 1'b1;
          end else begin
            w_nextState = CHK_HI;
          end
        end
      end

      CHK_HI: begin
        if (!r_s2) begin
          w_nextState = STABLE_LO;
          w_nextCnt   = '0;
        end else if (r_cnt == LAST_CNT) begin
          w_nextState = STABLE_HI;
          w_nextCnt   = '0;
          w_nextLevel = 1'b1;
          w_nextEdge  = 1'b1;
        end else begin
          w_nextCnt = r_cnt + 1'b1;
        end
      end

      STABLE_HI: begin
        if (!r_s2) begin
          w_nextCnt = '0;
          if (IMMEDIATE) begin
            w_nextState = STABLE_LO;
            w_nextLevel = 1'b0;
            w_nextEdge  = 1'b1;
          end else begin
            w_nextState = CHK_LO;
          end
        end
      end

      CHK_LO: begin
        if (r_s2) begin
          w_nextState = STABLE_HI;
          w_nextCnt   = '0;
        end else if (r_cnt == LAST_CNT) begin
          w_nextState = STABLE_LO;
          w_nextCnt   = '0;
          w_nextLevel = 1'b0;
          w_nextEdge  = 1'b1;
        end else begin
          w_nextCnt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_nextState = STABLE_LO;
        w_nextCnt   = '0;
        w_nextLevel = 1'b0;
      end
    endcase
  end

  assign o_level = r_level;
  assign o_edge  = r_edge;

endmodule

module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_edge,
  output logic b_edge
);

  InputDebounceChannel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chanA (
    .clk    (clk),
    .reset  (reset),
    .i_raw  (a_raw),
    .o_level(a),
    .o_edge (a_edge)
  );

  InputDebounceChannel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chanB (
    .clk    (clk),
    .reset  (reset),
    .i_raw  (b_raw),
    .o_level(b),
    .o_edge (b_edge)
  );

endmodule

// File: tb/tb_input_debounce.sv
// ---------------------------------------------------------------------------
// tb_input_debounce
//
// Directed testbench for input_debounce. Instance dut4 uses
// DEBOUNCE_CYCLES=4 and instance dut1 uses DEBOUNCE_CYCLES=1. Inputs change
// 1 time unit after a rising edge. Outputs are sampled at the same point,
// after each edge. Edge offset k=0 is the first edge that samples a new
// raw level.
// ---------------------------------------------------------------------------

module tb_input_debounce;

  logic clk;
  logic reset;
  logic aRaw, bRaw;
  logic a, b, aEdge, bEdge;
  logic aRaw1, bRaw1;
  logic a1, b1, aEdge1, bEdge1;

  int testsRun;
  int testsFailed;
  int edgeCount;

  input_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut4 (
    .clk   (clk),
    .reset (reset),
    .a_raw (aRaw),
    .b_raw (bRaw),
    .a     (a),
    .b     (b),
    .a_edge(aEdge),
    .b_edge(bEdge)
  );

  input_debounce #(.DEBOUNCE_CYCLES(1), .CNT_W(8)) dut1 (
    .clk   (clk),
    .reset (reset),
    .a_raw (aRaw1),
    .b_raw (bRaw1),
    .a     (a1),
    .b     (b1),
    .a_edge(aEdge1),
    .b_edge(bEdge1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic newA, input logic newB);
    aRaw = newA;
    bRaw = newB;
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset = 1'b1;
    aRaw  = 1'b0;
    bRaw  = 1'b0;
    aRaw1 = 1'b0;
    bRaw1 = 1'b0;

    // Reset state
    tick();
    tick();
    checkOutput("reset a", a, 1'b0);
    checkOutput("reset b", b, 1'b0);
    checkOutput("reset a_edge", aEdge, 1'b0);
    checkOutput("reset b_edge", bEdge, 1'b0);
    checkOutput("reset a n1", a1, 1'b0);
    reset = 1'b0;
    repeat (3) tick();

    // Clean rise on A: output and pulse on k=5, pulse gone on k=6
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k <= 7; k++) begin
      tick();
      checkOutput($sformatf("rise a k=%0d", k), a, (k >= 5));
      checkOutput($sformatf("rise a_edge k=%0d", k), aEdge, (k == 5));
      checkOutput($sformatf("rise b k=%0d", k), b, 1'b0);
    end

    // Clean fall on A: output and pulse on k=5
    applyStimulus(1'b0, 1'b0);
    for (int k = 0; k <= 7; k++) begin
      tick();
      checkOutput($sformatf("fall a k=%0d", k), a, (k < 5));
      checkOutput($sformatf("fall a_edge k=%0d", k), aEdge, (k == 5));
    end

    // Three-cycle pulse is shorter than four samples and is rejected
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k <= 11; k++) begin
      tick();
      if (k == 2) applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("short a k=%0d", k), a, 1'b0);
      checkOutput($sformatf("short a_edge k=%0d", k), aEdge, 1'b0);
    end

    // Bounce 1,0,1,1,0 then steady 1: one rise, 5 edges after last 0->1
    begin
      logic [4:0] bounce;
      bounce = 5'b10110;
      edgeCount = 0;
      for (int i = 4; i >= 0; i--) begin
        applyStimulus(bounce[i], 1'b0);
        tick();
        if (aEdge) edgeCount++;
        checkOutput($sformatf("bounce a i=%0d", i), a, 1'b0);
      end
    end
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k <= 9; k++) begin
      tick();
      if (aEdge) edgeCount++;
      checkOutput($sformatf("bounce rise a k=%0d", k), a, (k >= 5));
      checkOutput($sformatf("bounce a_edge k=%0d", k), aEdge, (k == 5));
    end
    checkOutput("bounce single pulse", (edgeCount == 1), 1'b1);

    applyStimulus(1'b0, 1'b0);
    repeat (10) tick();
    checkOutput("bounce settle low", a, 1'b0);

    // Simultaneous rise on A and B
    applyStimulus(1'b1, 1'b1);
    for (int k = 0; k <= 6; k++) begin
      tick();
      checkOutput($sformatf("both a k=%0d", k), a, (k >= 5));
      checkOutput($sformatf("both b k=%0d", k), b, (k >= 5));
      checkOutput($sformatf("both a_edge k=%0d", k), aEdge, (k == 5));
      checkOutput($sformatf("both b_edge k=%0d", k), bEdge, (k == 5));
    end

    // Reset from STABLE_HI clears everything without a pulse
    applyStimulus(1'b0, 1'b0);
    reset = 1'b1;
    for (int k = 0; k <= 1; k++) begin
      tick();
      checkOutput($sformatf("rst hi a k=%0d", k), a, 1'b0);
      checkOutput($sformatf("rst hi b k=%0d", k), b, 1'b0);
      checkOutput($sformatf("rst hi a_edge k=%0d", k), aEdge, 1'b0);
      checkOutput($sformatf("rst hi b_edge k=%0d", k), bEdge, 1'b0);
    end
    reset = 1'b0;

    // Reset two cycles into CHK_HI, A held high across release
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k <= 3; k++) begin
      tick();
      checkOutput($sformatf("pre-rst a k=%0d", k), a, 1'b0);
    end
    reset = 1'b1;
    for (int k = 0; k <= 1; k++) begin
      tick();
      checkOutput($sformatf("mid-rst a k=%0d", k), a, 1'b0);
      checkOutput($sformatf("mid-rst a_edge k=%0d", k), aEdge, 1'b0);
    end
    reset = 1'b0;
    edgeCount = 0;
    for (int k = 0; k <= 7; k++) begin
      tick();
      if (aEdge) edgeCount++;
      checkOutput($sformatf("post-rst a k=%0d", k), a, (k >= 5));
      checkOutput($sformatf("post-rst a_edge k=%0d", k), aEdge, (k == 5));
    end
    checkOutput("post-rst single pulse", (edgeCount == 1), 1'b1);

    // DEBOUNCE_CYCLES=1: 2-edge lag, pulse on each change
    aRaw1 = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      tick();
      if (k == 2) aRaw1 = 1'b0;
      checkOutput($sformatf("n1 a k=%0d", k), a1, (k >= 2 && k < 5));
      checkOutput($sformatf("n1 a_edge k=%0d", k), aEdge1, (k == 2 || k == 5));
      checkOutput($sformatf("n1 b k=%0d", k), b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
